// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle controller: FSM states, opcodes, ALU ops,
// writeback selects, trap causes and the decoded instruction class.
package ctrl_pkg;

  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StExec    = 3'd1;
  localparam state_t StMul     = 3'd2;
  localparam state_t StMem     = 3'd3;
  localparam state_t StPostinc = 3'd4;
  localparam state_t StTrap    = 3'd5;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcLwpi   = 7'b0101011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;
  localparam logic [6:0] F7Mret = 7'b0011000;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluLui  = 4'd10;
  localparam logic [3:0] AluMul  = 4'd11;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbCsr = 2'b10;

  localparam logic [3:0] CauseIllegal    = 4'd2;
  localparam logic [3:0] CauseLoadFault  = 4'd5;
  localparam logic [3:0] CauseStoreFault = 4'd7;
  localparam logic [3:0] CauseMachine    = 4'd11;

  typedef enum logic [3:0] {
    KindAlu, KindMul, KindLoad, KindLwpi, KindStore, KindCsr, KindMret, KindEcall, KindIllegal
  } kind_t;

  // func3 -> ALU op for the func7=0 register/immediate forms.
  function automatic logic [3:0] alu_base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return AluAdd;
      3'd1:    return AluSll;
      3'd2:    return AluSlt;
      3'd3:    return AluSltu;
      3'd4:    return AluXor;
      3'd5:    return AluSrl;
      3'd6:    return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// Loadable up/down counter shared by the multiply countdown and the memory timeout.
module ctrl_cycle_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end else if (dec_i) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: decodes the held instruction and steps it through
// EXEC / MUL / MEM / POSTINC / TRAP, handshaking with fetch and data memory.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MUL_EN       = 1,
  parameter int unsigned MUL_CYCLES   = 4,
  parameter int unsigned POSTINC_STEP = 4,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic            mem_ack,
  input  logic            irq,
  input  logic            mie,
  output logic [3:0]      aluop,
  output logic            rf_en,
  output logic            rd_sel,
  output logic            imm_en,
  output logic            inc_sel,
  output logic [XLEN-1:0] inc_value,
  output logic            sel_A,
  output logic            jump_en,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      wb_sel,
  output logic            csr_rd,
  output logic            csr_wr,
  output logic            is_mret,
  output logic            mul_start,
  output logic            trap_en,
  output logic [3:0]      trap_cause,
  output logic            instr_ack,
  output logic            busy
);

  localparam int unsigned CntMax = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MulLoad     = CntW'(MUL_CYCLES - 2);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cause_q, cause_d;
  kind_t           kind;
  logic [3:0]      dec_aluop;
  logic            dec_imm, dec_sel_a;
  logic            cnt_load, cnt_inc, cnt_dec;
  logic [CntW-1:0] cnt_load_val, cnt;
  logic            is_store, is_lwpi;

  assign inc_value = XLEN'(POSTINC_STEP);
  assign is_store  = (kind == KindStore);
  assign is_lwpi   = (kind == KindLwpi);

  // Instruction fields stay stable until instr_ack, so decode is valid in every busy state.
  always_comb begin
    kind      = KindIllegal;
    dec_aluop = AluAdd;
    dec_imm   = 1'b0;
    dec_sel_a = 1'b0;
    case (opcode)
      OpcOp: begin
        if (func7 == F7Mul) begin
          kind = (MUL_EN != 0) ? KindMul : KindIllegal;
        end else if (func7 == F7Base) begin
          kind      = KindAlu;
          dec_aluop = alu_base_op(func3);
        end else if (func7 == F7Alt && (func3 == 3'd0 || func3 == 3'd5)) begin
          kind      = KindAlu;
          dec_aluop = (func3 == 3'd0) ? AluSub : AluSra;
        end
      end
      OpcOpImm: begin
        dec_imm = 1'b1;
        if (func3 == 3'd1) begin
          if (func7 == F7Base) begin
            kind      = KindAlu;
            dec_aluop = AluSll;
          end
        end else if (func3 == 3'd5) begin
          if (func7 == F7Base || func7 == F7Alt) begin
            kind      = KindAlu;
            dec_aluop = (func7 == F7Alt) ? AluSra : AluSrl;
          end
        end else begin
          kind      = KindAlu;
          dec_aluop = alu_base_op(func3);
        end
      end
      OpcLui: begin
        kind      = KindAlu;
        dec_aluop = AluLui;
        dec_imm   = 1'b1;
      end
      OpcAuipc: begin
        kind      = KindAlu;
        dec_imm   = 1'b1;
        dec_sel_a = 1'b1;
      end
      OpcLoad:  kind = KindLoad;
      OpcLwpi:  kind = KindLwpi;
      OpcStore: kind = KindStore;
      OpcSystem: begin
        if (func3 != 3'd0)         kind = KindCsr;
        else if (func7 == F7Mret)  kind = KindMret;
        else if (func7 == F7Base)  kind = KindEcall;
      end
      default: kind = KindIllegal;
    endcase
  end

  always_comb begin
    aluop        = AluAdd;
    rf_en        = 1'b0;
    rd_sel       = 1'b0;
    imm_en       = 1'b0;
    inc_sel      = 1'b0;
    sel_A        = 1'b0;
    jump_en      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    wb_sel       = WbAlu;
    csr_rd       = 1'b0;
    csr_wr       = 1'b0;
    is_mret      = 1'b0;
    mul_start    = 1'b0;
    trap_en      = 1'b0;
    trap_cause   = '0;
    instr_ack    = 1'b0;
    busy         = (state_q != StIdle);
    state_d      = state_q;
    cause_d      = cause_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          if (irq && mie) begin
            state_d = StTrap;
            cause_d = CauseMachine;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        case (kind)
          KindAlu: begin
            aluop     = dec_aluop;
            imm_en    = dec_imm;
            sel_A     = dec_sel_a;
            rf_en     = 1'b1;
            instr_ack = 1'b1;
            state_d   = StIdle;
          end
          KindMul: begin
            mul_start    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = MulLoad;
            state_d      = StMul;
          end
          KindLoad, KindLwpi, KindStore: begin
            mem_read  = !is_store;
            mem_write = is_store;
            imm_en    = !is_lwpi;
            cnt_load  = 1'b1;
            state_d   = StMem;
          end
          KindCsr: begin
            csr_rd    = 1'b1;
            csr_wr    = 1'b1;
            rf_en     = 1'b1;
            wb_sel    = WbCsr;
            instr_ack = 1'b1;
            state_d   = StIdle;
          end
          KindMret: begin
            is_mret   = 1'b1;
            instr_ack = 1'b1;
            state_d   = StIdle;
          end
          KindEcall: begin
            state_d = StTrap;
            cause_d = CauseMachine;
          end
          default: begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StMul: begin
        if (cnt == '0) begin
          rf_en     = 1'b1;
          aluop     = AluMul;
          instr_ack = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StMem: begin
        mem_read  = !is_store;
        mem_write = is_store;
        imm_en    = !is_lwpi;
        // An ack on the last timeout cycle still completes the access.
        if (mem_ack) begin
          if (is_store) begin
            instr_ack = 1'b1;
            state_d   = StIdle;
          end else begin
            rf_en  = 1'b1;
            wb_sel = WbMem;
            if (is_lwpi) begin
              state_d = StPostinc;
            end else begin
              instr_ack = 1'b1;
              state_d   = StIdle;
            end
          end
        end else if (cnt == TimeoutLast) begin
          state_d = StTrap;
          cause_d = is_store ? CauseStoreFault : CauseLoadFault;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StPostinc: begin
        rf_en     = 1'b1;
        rd_sel    = 1'b1;
        inc_sel   = 1'b1;
        instr_ack = 1'b1;
        state_d   = StIdle;
      end
      StTrap: begin
        trap_en    = 1'b1;
        trap_cause = cause_q;
        instr_ack  = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  ctrl_cycle_counter #(
    .Width(CntW)
  ) u_cycle_counter (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .inc_i     (cnt_inc),
    .dec_i     (cnt_dec),
    .count_o   (cnt)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle sequences are built
// from the instruction classes and compared against both a MUL-enabled and a MUL-less DUT.
module tb_multicycle_controller;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MUL_CYCLES   = 4;
  localparam int unsigned POSTINC_STEP = 4;
  localparam int unsigned MEM_TIMEOUT  = 16;

  localparam int K_ALU = 0, K_MUL = 1, K_LOAD = 2, K_LWPI = 3, K_STORE = 4;
  localparam int K_CSR = 5, K_MRET = 6, K_ECALL = 7, K_ILL = 8;
  localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  typedef struct packed {
    logic [3:0] aluop;
    logic       rf_en, rd_sel, imm_en, inc_sel, sel_a, jump_en, mem_read, mem_write;
    logic [1:0] wb_sel;
    logic       csr_rd, csr_wr, is_mret, mul_start, trap_en;
    logic [3:0] trap_cause;
    logic       instr_ack, busy;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  logic instr_valid_a, instr_valid_b, mem_ack, irq, mie;
  logic [6:0] opcode, func7;
  logic [2:0] func3;

  logic [3:0] a_aluop, b_aluop, a_cause, b_cause;
  logic [1:0] a_wb_sel, b_wb_sel;
  logic [XLEN-1:0] a_inc_value, b_inc_value;
  logic a_rf_en, a_rd_sel, a_imm_en, a_inc_sel, a_sel_a, a_jump_en, a_mem_read, a_mem_write;
  logic a_csr_rd, a_csr_wr, a_is_mret, a_mul_start, a_trap_en, a_instr_ack, a_busy;
  logic b_rf_en, b_rd_sel, b_imm_en, b_inc_sel, b_sel_a, b_jump_en, b_mem_read, b_mem_write;
  logic b_csr_rd, b_csr_wr, b_is_mret, b_mul_start, b_trap_en, b_instr_ack, b_busy;
  outs_t act_a, act_b;

  int checks = 0;
  int failures = 0;
  outs_t expq[$];
  bit    ackq[$];

  always #5 clk = ~clk;

  multicycle_controller #(
    .XLEN(XLEN), .MUL_EN(1), .MUL_CYCLES(MUL_CYCLES), .POSTINC_STEP(POSTINC_STEP),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut_a (
    .clk(clk), .rst(rst), .instr_valid(instr_valid_a), .opcode(opcode), .func3(func3),
    .func7(func7), .mem_ack(mem_ack), .irq(irq), .mie(mie), .aluop(a_aluop),
    .rf_en(a_rf_en), .rd_sel(a_rd_sel), .imm_en(a_imm_en), .inc_sel(a_inc_sel),
    .inc_value(a_inc_value), .sel_A(a_sel_a), .jump_en(a_jump_en), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .wb_sel(a_wb_sel), .csr_rd(a_csr_rd), .csr_wr(a_csr_wr),
    .is_mret(a_is_mret), .mul_start(a_mul_start), .trap_en(a_trap_en),
    .trap_cause(a_cause), .instr_ack(a_instr_ack), .busy(a_busy)
  );

  multicycle_controller #(
    .XLEN(XLEN), .MUL_EN(0), .MUL_CYCLES(MUL_CYCLES), .POSTINC_STEP(POSTINC_STEP),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut_b (
    .clk(clk), .rst(rst), .instr_valid(instr_valid_b), .opcode(opcode), .func3(func3),
    .func7(func7), .mem_ack(mem_ack), .irq(irq), .mie(mie), .aluop(b_aluop),
    .rf_en(b_rf_en), .rd_sel(b_rd_sel), .imm_en(b_imm_en), .inc_sel(b_inc_sel),
    .inc_value(b_inc_value), .sel_A(b_sel_a), .jump_en(b_jump_en), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .wb_sel(b_wb_sel), .csr_rd(b_csr_rd), .csr_wr(b_csr_wr),
    .is_mret(b_is_mret), .mul_start(b_mul_start), .trap_en(b_trap_en),
    .trap_cause(b_cause), .instr_ack(b_instr_ack), .busy(b_busy)
  );

  assign act_a = {a_aluop, a_rf_en, a_rd_sel, a_imm_en, a_inc_sel, a_sel_a, a_jump_en,
                  a_mem_read, a_mem_write, a_wb_sel, a_csr_rd, a_csr_wr, a_is_mret,
                  a_mul_start, a_trap_en, a_cause, a_instr_ack, a_busy};
  assign act_b = {b_aluop, b_rf_en, b_rd_sel, b_imm_en, b_inc_sel, b_sel_a, b_jump_en,
                  b_mem_read, b_mem_write, b_wb_sel, b_csr_rd, b_csr_wr, b_is_mret,
                  b_mul_start, b_trap_en, b_cause, b_instr_ack, b_busy};

  // Instruction class and single-cycle ALU controls from the ISA encoding rules.
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input bit mul_en,
                                  output logic [3:0] alu, output logic imm,
                                  output logic sela);
    alu = 4'd0; imm = 1'b0; sela = 1'b0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h01) return mul_en ? K_MUL : K_ILL;
        if (f7 == 7'h00) begin alu = BASE_OP[f3]; return K_ALU; end
        if (f7 == 7'h20 && f3 == 3'd0) begin alu = 4'd1; return K_ALU; end
        if (f7 == 7'h20 && f3 == 3'd5) begin alu = 4'd7; return K_ALU; end
        return K_ILL;
      end
      7'b0010011: begin
        imm = 1'b1;
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) begin alu = 4'd2; return K_ALU; end
          return K_ILL;
        end
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) begin alu = 4'd6; return K_ALU; end
          if (f7 == 7'h20) begin alu = 4'd7; return K_ALU; end
          return K_ILL;
        end
        alu = BASE_OP[f3];
        return K_ALU;
      end
      7'b0110111: begin alu = 4'd10; imm = 1'b1; return K_ALU; end
      7'b0010111: begin imm = 1'b1; sela = 1'b1; return K_ALU; end
      7'b0000011: return K_LOAD;
      7'b0101011: return K_LWPI;
      7'b0100011: return K_STORE;
      7'b1110011: begin
        if (f3 != 3'd0) return K_CSR;
        if (f7 == 7'h18) return K_MRET;
        if (f7 == 7'h00) return K_ECALL;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  task automatic push(input outs_t e, input bit ack);
    expq.push_back(e);
    ackq.push_back(ack);
  endtask

  task automatic push_trap(input logic [3:0] cause);
    outs_t e = '0;
    e.busy = 1'b1; e.trap_en = 1'b1; e.trap_cause = cause; e.instr_ack = 1'b1;
    push(e, 1'b0);
  endtask

  // Expected outputs for every cycle from the IDLE acceptance cycle to the retire cycle.
  task automatic build_model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic irq_i, input logic mie_i, input bit mul_en,
                             input int d);
    outs_t e, base;
    logic [3:0] alu;
    logic imm, sela;
    int kind;
    expq.delete();
    ackq.delete();
    push('0, 1'b0);
    if (irq_i && mie_i) begin
      push_trap(4'd11);
      return;
    end
    kind = classify(op, f3, f7, mul_en, alu, imm, sela);
    e = '0;
    e.busy = 1'b1;
    case (kind)
      K_ALU: begin
        e.aluop = alu; e.imm_en = imm; e.sel_a = sela; e.rf_en = 1'b1; e.instr_ack = 1'b1;
        push(e, 1'b0);
      end
      K_CSR: begin
        e.csr_rd = 1'b1; e.csr_wr = 1'b1; e.rf_en = 1'b1; e.wb_sel = 2'b10; e.instr_ack = 1'b1;
        push(e, 1'b0);
      end
      K_MRET: begin
        e.is_mret = 1'b1; e.instr_ack = 1'b1;
        push(e, 1'b0);
      end
      K_ECALL: begin push(e, 1'b0); push_trap(4'd11); end
      K_ILL:   begin push(e, 1'b0); push_trap(4'd2); end
      K_MUL: begin
        e.mul_start = 1'b1;
        push(e, 1'b0);
        e.mul_start = 1'b0;
        for (int i = 0; i < int'(MUL_CYCLES) - 2; i++) push(e, 1'b0);
        e.rf_en = 1'b1; e.aluop = 4'd11; e.instr_ack = 1'b1;
        push(e, 1'b0);
      end
      default: begin
        base = e;
        base.mem_read  = (kind != K_STORE);
        base.mem_write = (kind == K_STORE);
        base.imm_en    = (kind != K_LWPI);
        push(base, 1'b0);
        for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
          if (k == d) begin
            e = base;
            if (kind == K_STORE) begin
              e.instr_ack = 1'b1;
            end else begin
              e.rf_en = 1'b1; e.wb_sel = 2'b01; e.instr_ack = (kind == K_LOAD);
            end
            push(e, 1'b1);
            if (kind == K_LWPI) begin
              e = '0;
              e.busy = 1'b1; e.rf_en = 1'b1; e.rd_sel = 1'b1; e.inc_sel = 1'b1;
              e.instr_ack = 1'b1;
              push(e, 1'b0);
            end
            return;
          end
          push(base, 1'b0);
        end
        push_trap((kind == K_STORE) ? 4'd7 : 4'd5);
      end
    endcase
  endtask

  // Presents one instruction and compares every cycle against the model.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic irq_i, input logic mie_i,
                           input bit use_b, input int d, input bit gap);
    outs_t act;
    build_model(op, f3, f7, irq_i, mie_i, !use_b, d);
    opcode = op; func3 = f3; func7 = f7; irq = irq_i; mie = mie_i;
    for (int i = 0; i < expq.size(); i++) begin
      instr_valid_a = !use_b;
      instr_valid_b = use_b;
      mem_ack = ackq[i];
      @(negedge clk);
      act = use_b ? act_b : act_a;
      checks++;
      if (act !== expq[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", name, i, act, expq[i]);
      end
      @(posedge clk); #1;
    end
    instr_valid_a = 1'b0;
    instr_valid_b = 1'b0;
    mem_ack = 1'b0;
    if (gap) begin
      @(negedge clk);
      act = use_b ? act_b : act_a;
      checks++;
      if (act !== '0) begin
        failures++;
        $display("FAIL %s idle-after: outputs %h, required 0", name, act);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (act_a !== '0 || act_b !== '0) begin
      failures++;
      $display("FAIL reset outputs: a=%h b=%h, required 0", act_a, act_b);
    end
    checks++;
    if (a_inc_value !== 32'd4 || b_inc_value !== 32'd4) begin
      failures++;
      $display("FAIL reset inc_value: a=%0d b=%0d, required 4", a_inc_value, b_inc_value);
    end
  endtask

  task automatic test_add();
    run_instr("add", 7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_lw();
    run_instr("lw_ack3", 7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 2, 1'b1);
  endtask

  task automatic test_lwpostinc();
    run_instr("lwpostinc", 7'b0101011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_mul();
    run_instr("mul", 7'b0110011, 3'd0, 7'h01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_mul_disabled();
    run_instr("mul_disabled", 7'b0110011, 3'd0, 7'h01, 1'b0, 1'b0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_store_timeout();
    int n = 0;
    bit found = 1'b0;
    run_instr("store_timeout", 7'b0100011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1000, 1'b1);
    opcode = 7'b0100011; func3 = 3'd2; func7 = 7'h00; instr_valid_a = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_trap_en === 1'b1) begin
        found = 1'b1;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (!found || n != 16 || a_cause !== 4'd7 || a_mem_write !== 1'b0) begin
      failures++;
      $display("FAIL store_timeout_count: trap after %0d cycles (seen=%0d) cause %0d wr %b, required 16 cause 7 wr 0",
               n, found, a_cause, a_mem_write);
    end
    @(posedge clk); #1;
    instr_valid_a = 1'b0;
  endtask

  task automatic test_irq();
    run_instr("irq_taken", 7'b0110011, 3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    run_instr("irq_masked", 7'b0110011, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_instr("irq_midinstr", 7'b0000011, 3'd2, 7'h00, 1'b1, 1'b1, 1'b0, 3, 1'b1);
  endtask

  task automatic test_reset_mid_mem();
    opcode = 7'b0000011; func3 = 3'd2; func7 = 7'h00; irq = 1'b0; mie = 1'b0;
    instr_valid_a = 1'b1; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_mem_read !== 1'b1 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_mem pre: mem_read %b busy %b, required 1 1", a_mem_read, a_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act_a !== '0 || a_inc_value !== 32'd4) begin
      failures++;
      $display("FAIL reset_mid_mem: outputs %h inc %0d, required 0 and 4", act_a, a_inc_value);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    instr_valid_a = 1'b0;
    @(negedge clk);
    checks++;
    if (act_a !== '0) begin
      failures++;
      $display("FAIL reset_mid_mem idle: outputs %h, required 0", act_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_addi", 7'b0010011, 3'd4, 7'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr("b2b_csr", 7'b1110011, 3'd1, 7'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr("b2b_mret", 7'b1110011, 3'd0, 7'h18, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr("b2b_ecall", 7'b1110011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr("b2b_store", 7'b0100011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 15, 1'b0);
    run_instr("b2b_lwpi_to", 7'b0101011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 16, 1'b1);
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [6:0] f7s [5];
    logic [6:0] op, f7;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
            7'b0101011, 7'b0100011, 7'b1110011, 7'h00};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h18, 7'h00};
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 8)];
      if (op == 7'h00) op = 7'($urandom);
      f7 = f7s[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) f7 = 7'($urandom);
      run_instr("random", op, 3'($urandom), f7, ($urandom_range(0, 3) == 0),
                1'($urandom), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, MEM_TIMEOUT + 3)), 1'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr_valid_a = 1'b0; instr_valid_b = 1'b0; mem_ack = 1'b0; irq = 1'b0; mie = 1'b0;
    opcode = '0; func3 = '0; func7 = '0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_add();
    test_lw();
    test_lwpostinc();
    test_mul();
    test_mul_disabled();
    test_store_timeout();
    test_irq();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
